// File: rtl/adc_sdo_responder_if.sv
// -----------------------------------------------------------------------------
// adc_sdo_responder_if
//
// Purpose : Bundles the serial ADC link (conversion strobe, serial clock and
//           per-lane serial data) so that the acquisition master and the ADC
//           responder can be connected with one port each.
//
// Signals :
//   i_adc_cnv_n  conversion strobe, driven by the master, falling edge starts
//                a conversion
//   i_adc_sck    serial clock, driven by the master, which samples SDO on the
//                rising edge
//   o_adc_sdo    serial data, one bit per lane, driven by the responder
//
// Modports:
//   master  acquisition side (drives CNV_n and SCK, reads SDO)
//   slave   ADC side (reads CNV_n and SCK, drives SDO)
// -----------------------------------------------------------------------------
interface adc_sdo_responder_if #(
   parameter int N_LANES = 2
);

   logic               i_adc_cnv_n;
   logic               i_adc_sck;
   logic [N_LANES-1:0] o_adc_sdo;

   modport master (
      output i_adc_cnv_n,
      output i_adc_sck,
      input  o_adc_sdo
   );

   modport slave (
      input  i_adc_cnv_n,
      input  i_adc_sck,
      output o_adc_sdo
   );

endinterface

// File: rtl/adc_sdo_responder.sv
// -----------------------------------------------------------------------------
// adc_sdo_responder
//
// Purpose : Plays the ADC side of a CNV_n/SCK/SDO serial link. A falling edge
//           on CNV_n latches one SAMPLE_BITS-bit word per lane, waits the
//           conversion time, then shifts every word out MSB first. The master
//           samples each bit on SCK rising edges. The next bit is presented
//           after each SCK falling edge. Protocol violations set a sticky
//           error flag.
//
// Parameters:
//   N_LANES       number of SDO lanes sharing one SCK
//   SAMPLE_BITS   bits per conversion word (2..32)
//   CONV_CYCLES   clk cycles of conversion time after CNV_n falls (>= 1)
//   SYNC_STAGES   synchronizer depth on CNV_n and SCK (>= 2)
//   PATTERN_SEED  base value of the generated data pattern
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   adc           serial link (slave modport): CNV_n, SCK in, SDO out
//   o_busy        high while converting or shifting
//   o_frame_done  one-cycle pulse when a frame completes
//   o_frame_cnt   number of completed frames (wraps at 2^32)
//   o_err         sticky protocol error flag
//   i_clr_err     synchronous clear of o_err (a same-cycle set wins)
//   i_ext_data    only with ADC_RESP_EXT_DATA_EN: external words, lane k in
//                 bits [k*SAMPLE_BITS +: SAMPLE_BITS]
//
// Build option:
//   ADC_RESP_EXT_DATA_EN  when defined, each conversion latches i_ext_data
//                         instead of the generated pattern
//                         (PATTERN_SEED + o_frame_cnt + lane).
// -----------------------------------------------------------------------------
module adc_sdo_responder #(
   parameter int                     N_LANES      = 2,
   parameter int                     SAMPLE_BITS  = 16,
   parameter int                     CONV_CYCLES  = 8,
   parameter int                     SYNC_STAGES  = 2,
   parameter logic [SAMPLE_BITS-1:0] PATTERN_SEED = 16'hA500
) (
   input  logic                           clk,
   input  logic                           rst,
   adc_sdo_responder_if.slave             adc,
   output logic                           o_busy,
   output logic                           o_frame_done,
   output logic [31:0]                    o_frame_cnt,
   output logic                           o_err,
   input  logic                           i_clr_err
`ifdef ADC_RESP_EXT_DATA_EN
   ,
   input  logic [N_LANES*SAMPLE_BITS-1:0] i_ext_data
`endif
);

   localparam int CONV_W = $clog2(CONV_CYCLES + 1);
   localparam int BIT_W  = $clog2(SAMPLE_BITS + 1);

   localparam logic [CONV_W-1:0] CONV_LOAD = CONV_W'(CONV_CYCLES - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SAMPLE_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      SHIFT
   } state_t;

   state_t                 state;

   logic [SYNC_STAGES-1:0] cnv_sync;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic                   cnv_last;
   logic                   sck_last;
   logic                   cnv_fall;
   logic                   sck_rise;
   logic                   sck_fall;

   logic [SAMPLE_BITS-1:0] load_word [N_LANES];
   logic [SAMPLE_BITS-1:0] shreg     [N_LANES];
   logic [N_LANES-1:0]     sdo_q;
   logic [CONV_W-1:0]      conv_cnt;
   logic [BIT_W-1:0]       bit_cnt;

   // CNV_n and SCK come from another clock domain, so each goes through a
   // plain flop chain before edge detection. The strobe chain resets high
   // (its idle level) so that leaving reset with CNV_n high does not look
   // like an edge. SCK resets low for the same reason.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnv_sync <= '1;
         cnv_last <= 1'b1;
         sck_sync <= '0;
         sck_last <= 1'b0;
      end else begin
         cnv_sync <= {cnv_sync[SYNC_STAGES-2:0], adc.i_adc_cnv_n};
         cnv_last <= cnv_sync[SYNC_STAGES-1];
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], adc.i_adc_sck};
         sck_last <= sck_sync[SYNC_STAGES-1];
      end
   end

   // Single-cycle edge pulses on the synchronized levels. Only edges are
   // used, so a stale SCK high level at frame start is harmless.
   always_comb begin
      cnv_fall = cnv_last & ~cnv_sync[SYNC_STAGES-1];
      sck_rise = ~sck_last & sck_sync[SYNC_STAGES-1];
      sck_fall = sck_last & ~sck_sync[SYNC_STAGES-1];
   end

   // The word each lane latches on a conversion start. The generated pattern
   // depends on the completed-frame count, so an aborted frame, which does
   // not count, is re-latched with exactly the same words.
   always_comb begin
      for (int k = 0; k < N_LANES; k++) begin
`ifdef ADC_RESP_EXT_DATA_EN
         load_word[k] = i_ext_data[k*SAMPLE_BITS +: SAMPLE_BITS];
`else
         load_word[k] = PATTERN_SEED + o_frame_cnt[SAMPLE_BITS-1:0] + SAMPLE_BITS'(k);
`endif
      end
   end

   // Main protocol FSM. SDO is driven from a register that holds the current
   // bit of each lane. It is loaded with the MSB when conversion ends and
   // advanced on every SCK fall that follows at least one rise. The frame
   // ends on the SAMPLE_BITS-th SCK rise, when the master has taken the LSB.
   // o_err is cleared first and set afterwards in the same pass, so a set in
   // the same cycle as i_clr_err wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         for (int k = 0; k < N_LANES; k++) begin
            shreg[k] <= '0;
         end
         sdo_q        <= '0;
         conv_cnt     <= '0;
         bit_cnt      <= '0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_cnt  <= '0;
         o_err        <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         if (i_clr_err) begin
            o_err <= 1'b0;
         end

         case (state)
            IDLE: begin
               sdo_q <= '0;
               if (cnv_fall) begin
                  for (int k = 0; k < N_LANES; k++) begin
                     shreg[k] <= load_word[k];
                  end
                  conv_cnt <= CONV_LOAD;
                  bit_cnt  <= '0;
                  o_busy   <= 1'b1;
                  state    <= CONVERT;
               end
            end

            CONVERT: begin
               if (cnv_fall) begin
                  o_err <= 1'b1;
                  for (int k = 0; k < N_LANES; k++) begin
                     shreg[k] <= load_word[k];
                  end
                  conv_cnt <= CONV_LOAD;
               end else begin
                  if (sck_rise) begin
                     o_err <= 1'b1;
                  end
                  if (conv_cnt == '0) begin
                     for (int k = 0; k < N_LANES; k++) begin
                        sdo_q[k] <= shreg[k][SAMPLE_BITS-1];
                     end
                     bit_cnt <= '0;
                     state   <= SHIFT;
                  end else begin
                     conv_cnt <= conv_cnt - 1'b1;
                  end
               end
            end

            SHIFT: begin
               if (cnv_fall) begin
                  o_err <= 1'b1;
                  for (int k = 0; k < N_LANES; k++) begin
                     shreg[k] <= load_word[k];
                  end
                  conv_cnt <= CONV_LOAD;
                  bit_cnt  <= '0;
                  sdo_q    <= '0;
                  state    <= CONVERT;
               end else if (sck_rise) begin
                  if (bit_cnt == LAST_BIT) begin
                     o_frame_done <= 1'b1;
                     o_frame_cnt  <= o_frame_cnt + 32'd1;
                     sdo_q        <= '0;
                     bit_cnt      <= '0;
                     o_busy       <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (sck_fall && (bit_cnt != '0)) begin
                  for (int k = 0; k < N_LANES; k++) begin
                     sdo_q[k] <= shreg[k][SAMPLE_BITS-2];
                     shreg[k] <= shreg[k] << 1;
                  end
               end
            end

            default: begin
               sdo_q  <= '0;
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign adc.o_adc_sdo = sdo_q;

endmodule

// File: tb/tb_adc_sdo_responder.sv
// -----------------------------------------------------------------------------
// tb_adc_sdo_responder
//
// Directed bench for adc_sdo_responder: acts as the acquisition master,
// drives CNV_n/SCK with 8-cycle SCK phases and compares the shifted words,
// frame counter, done pulses, busy and error flags against hand-derived
// values. With ADC_RESP_EXT_DATA_EN defined it drives i_ext_data instead and
// expects those words on every frame.
// -----------------------------------------------------------------------------
module tb_adc_sdo_responder;

   localparam int N_LANES = 2;
   localparam int HALF    = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        o_busy;
   logic        o_frame_done;
   logic [31:0] o_frame_cnt;
   logic        o_err;
   logic        i_clr_err = 1'b0;
`ifdef ADC_RESP_EXT_DATA_EN
   logic [31:0] extData = 32'h1234_BEEF;
`endif

   int passCount   = 0;
   int checkCount  = 0;
   int donePulses  = 0;
   logic [31:0] cntAtDone = '0;

   adc_sdo_responder_if #(.N_LANES(N_LANES)) bus ();

   adc_sdo_responder #(
      .N_LANES     (N_LANES),
      .SAMPLE_BITS (16),
      .CONV_CYCLES (8),
      .SYNC_STAGES (2),
      .PATTERN_SEED(16'hA500)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .adc         (bus),
      .o_busy      (o_busy),
      .o_frame_done(o_frame_done),
      .o_frame_cnt (o_frame_cnt),
      .o_err       (o_err),
      .i_clr_err   (i_clr_err)
`ifdef ADC_RESP_EXT_DATA_EN
      ,
      .i_ext_data  (extData)
`endif
   );

   // 10 time-unit clock; the bench drives and samples on the falling edge.
   always #5 clk = ~clk;

   // Count done pulses and record the frame count seen alongside each one.
   always @(negedge clk) begin
      if (o_frame_done === 1'b1) begin
         donePulses++;
         cntAtDone = o_frame_cnt;
      end
   end

   // Expected word for a given frame index and lane.
   function automatic logic [15:0] expWord(input int idx, input int lane);
`ifdef ADC_RESP_EXT_DATA_EN
      logic [31:0] ext;
      ext = 32'h1234_BEEF;
      expWord = ext[lane*16 +: 16];
`else
      expWord = 16'(16'hA500 + idx + lane);
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic cnv, input logic sck, input logic clr,
                                input int cycles);
      bus.i_adc_cnv_n = cnv;
      bus.i_adc_sck   = sck;
      i_clr_err       = clr;
      repeat (cycles) @(negedge clk);
   endtask

   // Falling CNV_n, released after a few cycles, then wait out sync plus
   // conversion time with margin so the MSB is on SDO.
   task automatic startConversion();
      applyStimulus(1'b0, 1'b0, 1'b0, 4);
      applyStimulus(1'b1, 1'b0, 1'b0, 12);
   endtask

   // Sample SDO as the master would just before the SCK rise, then run one
   // full SCK period.
   task automatic shiftBit(output logic [N_LANES-1:0] bits);
      bits = bus.o_adc_sdo;
      applyStimulus(1'b1, 1'b1, 1'b0, HALF);
      applyStimulus(1'b1, 1'b0, 1'b0, HALF);
   endtask

   task automatic readWords(input int nbits, output logic [15:0] w0, output logic [15:0] w1);
      logic [N_LANES-1:0] b;
      w0 = '0;
      w1 = '0;
      for (int i = 0; i < nbits; i++) begin
         shiftBit(b);
         w0 = {w0[14:0], b[0]};
         w1 = {w1[14:0], b[1]};
      end
   endtask

   task automatic fullFrame(input string tag, input int idx, input int expCnt);
      logic [15:0] w0;
      logic [15:0] w1;
      int          pulsesBefore;
      pulsesBefore = donePulses;
      startConversion();
      checkOutput({tag, "_busy"}, o_busy, 1'b1);
      readWords(16, w0, w1);
      checkOutput({tag, "_lane0"}, w0, expWord(idx, 0));
      checkOutput({tag, "_lane1"}, w1, expWord(idx, 1));
      checkOutput({tag, "_done_pulses"}, donePulses - pulsesBefore, 1);
      checkOutput({tag, "_cnt_at_done"}, cntAtDone, expCnt);
      checkOutput({tag, "_cnt"}, o_frame_cnt, expCnt);
      checkOutput({tag, "_idle_busy"}, o_busy, 1'b0);
      checkOutput({tag, "_idle_sdo"}, bus.o_adc_sdo, 2'b00);
   endtask

   initial begin
      logic [15:0] w0;
      logic [15:0] w1;
      int          pulsesBefore;

      bus.i_adc_cnv_n = 1'b1;
      bus.i_adc_sck   = 1'b0;

      // Reset state
      repeat (5) @(negedge clk);
      checkOutput("reset_sdo", bus.o_adc_sdo, 2'b00);
      checkOutput("reset_busy", o_busy, 1'b0);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 4);
      checkOutput("reset_done", o_frame_done, 1'b0);
      checkOutput("reset_cnt", o_frame_cnt, 32'd0);
      checkOutput("reset_err", o_err, 1'b0);

      // First frame, then two back-to-back frames
      fullFrame("frame1", 0, 1);
      checkOutput("frame1_err", o_err, 1'b0);
      fullFrame("frame2", 1, 2);
      fullFrame("frame3", 2, 3);

      // SCK rises 2 cycles after CNV_n falls, during conversion
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 4);
      applyStimulus(1'b1, 1'b0, 1'b0, 10);
      checkOutput("early_sck_err", o_err, 1'b1);
      readWords(16, w0, w1);
      checkOutput("early_sck_lane0", w0, expWord(3, 0));
      checkOutput("early_sck_cnt", o_frame_cnt, 32'd4);
      applyStimulus(1'b1, 1'b0, 1'b1, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      checkOutput("clr_err", o_err, 1'b0);
      fullFrame("clean", 4, 5);
      checkOutput("clean_err", o_err, 1'b0);

      // CNV_n falls again after 7 SCK bits
      pulsesBefore = donePulses;
      startConversion();
      readWords(7, w0, w1);
      checkOutput("abort_partial0", w0, 32'(expWord(5, 0) >> 9));
      startConversion();
      checkOutput("abort_err", o_err, 1'b1);
      checkOutput("abort_no_done", donePulses - pulsesBefore, 0);
      checkOutput("abort_cnt", o_frame_cnt, 32'd5);
      checkOutput("abort_busy", o_busy, 1'b1);
      readWords(16, w0, w1);
      checkOutput("retry_lane0", w0, expWord(5, 0));
      checkOutput("retry_lane1", w1, expWord(5, 1));
      checkOutput("retry_cnt", o_frame_cnt, 32'd6);
      applyStimulus(1'b1, 1'b0, 1'b1, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 2);

      // Reset asserted during bit 10
      startConversion();
      readWords(10, w0, w1);
      checkOutput("pre_rst_partial1", w1, 32'(expWord(6, 1) >> 6));
      applyStimulus(1'b1, 1'b1, 1'b0, 3);
      checkOutput("pre_rst_busy", o_busy, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("rst_sdo", bus.o_adc_sdo, 2'b00);
      checkOutput("rst_busy", o_busy, 1'b0);
      checkOutput("rst_cnt", o_frame_cnt, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 3);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 3);
      fullFrame("post_rst", 0, 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/adc_sdo_responder.md
# adc_sdo_responder

Behavioural, synthesizable responder for the serial ADC interface: it plays the ADC side of the CNV_n/SCK/SDO link that the acquisition logic drives. It senses the conversion strobe and serial clock and returns one SAMPLE_BITS-bit word per lane, MSB first, on SDO. It is used in simulation and as an on-board loopback target, with one instance per SCK group.

## Interface
- N_LANES, 2: SDO lanes sharing one SCK.
- SAMPLE_BITS, 16: bits per conversion word.
- CONV_CYCLES, 8: clk cycles of conversion time after CNV_n falls.
- SYNC_STAGES, 2: synchronizer flops on CNV_n and SCK.
- PATTERN_SEED, 16'hA500: base value of the generated pattern.

- clk  in  1: system clock; all logic is on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- i_adc_cnv_n  in  1: conversion strobe; its falling edge starts a conversion.
- i_adc_sck  in  1: serial clock; the master samples SDO on the SCK rising edge.
- o_adc_sdo  out  N_LANES: serial data, one bit per lane.
- o_busy  out  1: high in the CONVERT and SHIFT states.
- o_frame_done  out  1: one-cycle pulse when a frame completes.
- o_frame_cnt  out  32: number of completed frames.
- o_err  out  1: sticky protocol error flag.
- i_clr_err  in  1: synchronous clear of o_err.

## Operation
- CNV_n and SCK each pass through SYNC_STAGES flops and then an edge detector. This yields single-cycle pulses cnv_fall, sck_rise and sck_fall.
- Pattern: word_k = (PATTERN_SEED + o_frame_cnt + k) mod 2^SAMPLE_BITS, for lanes k = 0 to N_LANES-1. It is latched into per-lane shift registers on cnv_fall.
- States: IDLE, CONVERT, SHIFT.
- IDLE:
  - o_adc_sdo = 0.
  - cnv_fall: latch the words, load conv_cnt = CONV_CYCLES-1, go to CONVERT.
  - sck_rise: ignored; no error.
- CONVERT:
  - o_adc_sdo = 0.
  - conv_cnt decrements each cycle. At 0, drive the MSB of each word and go to SHIFT with bit_cnt = 0.
  - sck_rise or cnv_fall in CONVERT: set o_err. A cnv_fall also restarts CONVERT with a freshly latched pattern; o_frame_cnt is unchanged.
- SHIFT:
  - sck_rise: bit_cnt++.
    - If bit_cnt reaches SAMPLE_BITS: pulse o_frame_done, increment o_frame_cnt (wraps at 2^32), drive o_adc_sdo = 0, go to IDLE.
  - sck_fall after at least one sck_rise: shift every lane left by one and present the next bit.
  - cnv_fall mid-frame: set o_err, discard the frame (no done pulse, no count), relatch, go to CONVERT.
- o_err is set by the events above.
  - It is cleared by i_clr_err.
  - If set and clear occur in the same cycle, set wins.
- The SCK input must be held low in IDLE and CONVERT. A stale high level at frame start is harmless, because only edges are used.

## Timing
- Reset values: o_adc_sdo = 0, o_busy = 0, o_frame_done = 0, o_frame_cnt = 0, o_err = 0, state IDLE. The shift registers and counters are cleared.
- Input-to-detect latency is SYNC_STAGES+1 clk cycles for both CNV_n and SCK.
- MSB valid on SDO: SYNC_STAGES+1+CONV_CYCLES cycles after the external CNV_n falling edge. The master must not raise SCK before this.
- Bit n+1 is valid SYNC_STAGES+2 cycles after the external SCK falling edge.
- SCK high and low phases must each be at least SYNC_STAGES+2 clk cycles. No faster SCK is supported.
- o_busy is registered and rises in the cycle after cnv_fall is detected.
- o_frame_done is high in the same cycle that o_frame_cnt shows its new value.
- Asserting rst mid-frame forces SDO to 0 and the state to IDLE immediately (asynchronous). The next frame starts from pattern index 0.

## Configuration
- ADC_RESP_EXT_DATA_EN defined:
  - Adds the input i_ext_data, N_LANES*SAMPLE_BITS wide, with lane k at bits [k*SAMPLE_BITS +: SAMPLE_BITS].
  - i_ext_data is latched on cnv_fall in place of the pattern.
  - All other behaviour is identical.
- Undefined: the port is absent and the internal PATTERN_SEED pattern is used.

## Test plan
- Reset, then one frame with 16 SCK periods of 8 clk high / 8 clk low -> lane0 shifts out 0xA500, lane1 shifts out 0xA501, one o_frame_done pulse, o_frame_cnt = 1, o_err = 0.
- Three back-to-back frames -> the third frame returns 0xA502 and 0xA503; o_frame_cnt = 3.
- SCK rise 2 cycles after CNV_n falls -> o_err = 1. i_clr_err then clears it, and a following clean frame leaves it at 0.
- CNV_n falls after 7 SCK bits -> o_err = 1, no done pulse, o_frame_cnt unchanged. The next full frame returns the same words as the aborted frame.
- rst asserted at bit 10 -> SDO = 0 and o_busy = 0 combinationally. After release, the next frame returns 0xA500.
- With ADC_RESP_EXT_DATA_EN and i_ext_data = 32'h1234_BEEF -> lane0 = 0xBEEF, lane1 = 0x1234.
